sram_arb2p: RTL and testbench

Parametrised single-array SRAM with two independent request channels (A: USB protocol-engine side, B: WISHBONE/host side) and built-in round-robin arbitration. Replaces the bare one-port buffer memory. Adds per-byte write enables, registered reads with a valid strobe, and defined out-of-range behaviour. Sits between the USB core's memory interface and the host bus bridge. Both channels run on the single core clock.

---
 rtl/sram_arb2p_if.sv | 34 +++
 rtl/sram_arb2p.sv | 214 +++++++++++++++++++++
 tb/tb_sram_arb2p.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb2p_if.sv
// sram_arb2p_if: one request channel of the two-port arbitrated SRAM.
// The requester drives through the master modport and the memory answers
// through the slave modport.
// Optional feature macro (see sram_arb2p.sv): SRAM_ARB2P_PARITY_EN.
`ifndef USBF_SSRAM_HADR
`define USBF_SSRAM_HADR 14
`endif

interface sram_arb2p_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = `USBF_SSRAM_HADR + 1
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  perr;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata, rvalid, perr
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata, rvalid, perr
    );
endinterface

// File: rtl/sram_arb2p.sv
// sram_arb2p: single-array SRAM shared by two request channels (A: USB
// protocol engine, B: host bus) with round-robin arbitration, per-byte write
// enables, registered reads with a one-cycle valid strobe, and defined
// behaviour for addresses at or beyond DEPTH.
// Optional feature macro: SRAM_ARB2P_PARITY_EN (per-byte even parity with
// error flag on read). When undefined, a.perr/b.perr are tied low.
`ifndef USBF_SSRAM_HADR
`define USBF_SSRAM_HADR 14
`endif

module sram_arb2p #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = `USBF_SSRAM_HADR + 1,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    sram_arb2p_if.slave    a,
    sram_arb2p_if.slave    b
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        LG_A = 1'b0,
        LG_B = 1'b1
    } grant_e;

    grant_e last_grant;
    grant_e last_grant_nxt;
    logic   grant_a;
    logic   grant_b;

    logic                  acc_en;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [BE_WIDTH-1:0]   acc_be;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  wr_en;
    logic                  rd_a;
    logic                  rd_b;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;
    logic                  a_rvalid_q;
    logic                  b_rvalid_q;

    // Priority state register: remembers which channel was granted last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= LG_B;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Next priority state: follows whichever channel is granted this edge
    always_comb begin
        last_grant_nxt = last_grant;
        if (grant_a) begin
            last_grant_nxt = LG_A;
        end else if (grant_b) begin
            last_grant_nxt = LG_B;
        end
    end

    // Grant decode: sole requester wins, a tie goes to the channel not granted last
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a.req && (!b.req || last_grant == LG_B)) begin
                grant_a = 1'b1;
            end else if (b.req) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a.ack = grant_a;
    assign b.ack = grant_b;

    // Steer the granted channel onto the single array port
    always_comb begin
        acc_we    = a.we;
        acc_addr  = a.addr;
        acc_be    = a.be;
        acc_wdata = a.wdata;
        if (grant_b) begin
            acc_we    = b.we;
            acc_addr  = b.addr;
            acc_be    = b.be;
            acc_wdata = b.wdata;
        end
    end

    assign acc_en   = grant_a | grant_b;
    assign in_range = ({1'b0, acc_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign idx      = IDX_W'(acc_addr);
    assign wr_en    = acc_en & acc_we & in_range;
    assign rd_a     = grant_a & ~a.we;
    assign rd_b     = grant_b & ~b.we;

    // Array read port; addresses past the implemented depth read as zero
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[idx];
        end
    end

    // Array write port with per-byte enables; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (acc_be[i]) begin
                    mem[idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Channel A read capture and one-cycle valid strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= rd_a;
            if (rd_a) begin
                a_rdata_q <= rd_word;
            end
        end
    end

    // Channel B read capture and one-cycle valid strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
        end else begin
            b_rvalid_q <= rd_b;
            if (rd_b) begin
                b_rdata_q <= rd_word;
            end
        end
    end

    assign a.rdata  = a_rdata_q;
    assign a.rvalid = a_rvalid_q;
    assign b.rdata  = b_rdata_q;
    assign b.rvalid = b_rvalid_q;

`ifdef SRAM_ARB2P_PARITY_EN
    logic [BE_WIDTH-1:0] par_mem [DEPTH];
    logic [BE_WIDTH-1:0] wr_par;
    logic [BE_WIDTH-1:0] rd_par_calc;
    logic                rd_perr;
    logic                a_perr_q;
    logic                b_perr_q;

    // Even parity per byte for the incoming write and the outgoing read word
    always_comb begin
        wr_par      = '0;
        rd_par_calc = '0;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            wr_par[i]      = ^acc_wdata[i*8 +: 8];
            rd_par_calc[i] = ^rd_word[i*8 +: 8];
        end
    end

    // Any byte whose stored parity disagrees flags the read; out-of-range never does
    always_comb begin
        rd_perr = 1'b0;
        if (in_range) begin
            rd_perr = |(par_mem[idx] ^ rd_par_calc);
        end
    end

    // Parity bits are written alongside each enabled byte
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (acc_be[i]) begin
                    par_mem[idx][i] <= wr_par[i];
                end
            end
        end
    end

    // Parity error flags, aligned with each channel's rvalid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_perr_q <= 1'b0;
            b_perr_q <= 1'b0;
        end else begin
            a_perr_q <= rd_a & rd_perr;
            b_perr_q <= rd_b & rd_perr;
        end
    end

    assign a.perr = a_perr_q;
    assign b.perr = b_perr_q;
`else
    assign a.perr = 1'b0;
    assign b.perr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arb2p.sv
// Bench for sram_arb2p: table-driven accesses with a read scoreboard, plus
// hand-written reset, arbitration, abandon and reset-abort sequences.
// Instance u0 has the full 1024-word depth, u1 implements only 1000 words.
module tb_sram_arb2p;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sram_arb2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia ();
    sram_arb2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib ();
    sram_arb2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ja ();
    sram_arb2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) jb ();

    sram_arb2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024)) u0 (
        .clk(clk), .rst(rst), .a(ia), .b(ib)
    );
    sram_arb2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1000)) u1 (
        .clk(clk), .rst(rst), .a(ja), .b(jb)
    );

    typedef struct {
        logic [31:0] data;
        logic        perr;
        int          cyc;
    } exp_t;

    typedef struct {
        int          k;
        logic        we;
        logic [AW-1:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    exp_t sbq [4][$];
    vec_t vt [21];

    logic [3:0]  rv;
    logic [3:0]  pe;
    logic [31:0] rd [4];

    always_comb begin
        rv    = {jb.rvalid, ja.rvalid, ib.rvalid, ia.rvalid};
        pe    = {jb.perr, ja.perr, ib.perr, ia.perr};
        rd[0] = ia.rdata;
        rd[1] = ib.rdata;
        rd[2] = ja.rdata;
        rd[3] = jb.rdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        case (k)
            0: begin ia.req = req; ia.we = we; ia.addr = addr; ia.be = be; ia.wdata = wd; end
            1: begin ib.req = req; ib.we = we; ib.addr = addr; ib.be = be; ib.wdata = wd; end
            2: begin ja.req = req; ja.we = we; ja.addr = addr; ja.be = be; ja.wdata = wd; end
            default: begin jb.req = req; jb.we = we; jb.addr = addr; jb.be = be; jb.wdata = wd; end
        endcase
    endtask

    function automatic logic ack_of(input int k);
        case (k)
            0: return ia.ack;
            1: return ib.ack;
            2: return ja.ack;
            default: return jb.ack;
        endcase
    endfunction

    // Scoreboard: every rvalid pulse must match the oldest pending read of that channel
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (rv[k]) begin
                    if (sbq[k].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL spurious_rvalid ch%0d: got rvalid=1 want 0", k);
                    end else begin
                        exp_t e;
                        e = sbq[k].pop_front();
                        check($sformatf("rdata ch%0d", k), rd[k], e.data);
                        check($sformatf("perr ch%0d", k), 32'(pe[k]), 32'(e.perr));
                        check($sformatf("rvalid_cycle ch%0d", k), 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    // One access; caller sits just after a rising edge, returns just after the access edge
    task automatic access(input int k, input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp, input logic eperr);
        logic got;
        got = 1'b0;
        set_ch(k, 1'b1, we, addr, be, wd);
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            got = ack_of(k);
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout ch%0d addr %h: got ack=0 want 1", k, addr);
        end else if (!we) begin
            exp_t e;
            e.data = exp;
            e.perr = eperr;
            e.cyc  = cyc + 1;
            sbq[k].push_back(e);
        end
        @(posedge clk);
        #1;
        set_ch(k, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{0, 1'b1, 10'h010, 4'h1, 32'h00000055, 32'h0};
        vt[2]  = '{0, 1'b0, 10'h010, 4'h0, 32'h0,        32'hDEADBE55};
        vt[3]  = '{1, 1'b1, 10'h3FF, 4'hF, 32'h12345678, 32'h0};
        vt[4]  = '{0, 1'b0, 10'h3FF, 4'h0, 32'h0,        32'h12345678};
        vt[5]  = '{1, 1'b0, 10'h010, 4'h0, 32'h0,        32'hDEADBE55};
        vt[6]  = '{1, 1'b1, 10'h020, 4'hF, 32'hA5A5A5A5, 32'h0};
        vt[7]  = '{0, 1'b1, 10'h020, 4'h0, 32'hFFFFFFFF, 32'h0};
        vt[8]  = '{1, 1'b0, 10'h020, 4'h0, 32'h0,        32'hA5A5A5A5};
        vt[9]  = '{0, 1'b1, 10'h020, 4'hA, 32'h11223344, 32'h0};
        vt[10] = '{0, 1'b0, 10'h020, 4'h0, 32'h0,        32'h11A533A5};
        vt[11] = '{0, 1'b0, 10'h010, 4'h0, 32'h0,        32'hDEADBE55};
        vt[12] = '{1, 1'b1, 10'h000, 4'hF, 32'h0BADF00D, 32'h0};
        vt[13] = '{1, 1'b0, 10'h000, 4'h0, 32'h0,        32'h0BADF00D};
        vt[14] = '{2, 1'b1, 10'h3E7, 4'hF, 32'hCAFEF00D, 32'h0};
        vt[15] = '{2, 1'b1, 10'h3E8, 4'hF, 32'hFFFFFFFF, 32'h0};
        vt[16] = '{3, 1'b0, 10'h3E8, 4'h0, 32'h0,        32'h00000000};
        vt[17] = '{2, 1'b0, 10'h3E7, 4'h0, 32'h0,        32'hCAFEF00D};
        vt[18] = '{3, 1'b1, 10'h3FF, 4'hF, 32'h87654321, 32'h0};
        vt[19] = '{3, 1'b0, 10'h3FF, 4'h0, 32'h0,        32'h00000000};
        vt[20] = '{2, 1'b0, 10'h3E7, 4'h0, 32'h0,        32'hCAFEF00D};

        // Reset held with both u0 channels requesting (no-op writes)
        rst = 1'b1;
        for (int k = 0; k < 4; k++) set_ch(k, 1'b0, 1'b0, '0, '0, '0);
        set_ch(0, 1'b1, 1'b1, '0, 4'h0, '0);
        set_ch(1, 1'b1, 1'b1, '0, 4'h0, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset a_ack", 32'(ia.ack), 32'h0);
            check("reset b_ack", 32'(ib.ack), 32'h0);
            check("reset a_rvalid", 32'(ia.rvalid), 32'h0);
            check("reset b_rvalid", 32'(ib.rvalid), 32'h0);
            check("reset a_rdata", ia.rdata, 32'h0);
            check("reset b_rdata", ib.rdata, 32'h0);
            check("reset a_perr", 32'(ia.perr), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous dual requests alternate, starting with A
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rr%0d a_ack", i), 32'(ia.ack), (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("rr%0d b_ack", i), 32'(ib.ack), (i % 2 == 0) ? 32'h0 : 32'h1);
            check($sformatf("rr%0d both_ack", i), 32'(ia.ack & ib.ack), 32'h0);
        end
        @(posedge clk);
        #1;
        set_ch(0, 1'b0, 1'b0, '0, '0, '0);
        set_ch(1, 1'b0, 1'b0, '0, '0, '0);

        // Table-driven accesses
        for (int v = 0; v < 21; v++) begin
            access(vt[v].k, vt[v].we, vt[v].addr, vt[v].be, vt[v].wd, vt[v].exp, 1'b0);
        end

        // Abandoned request: B loses the tie (last grant was B) and withdraws
        set_ch(0, 1'b1, 1'b1, 10'h030, 4'h0, '0);
        set_ch(1, 1'b1, 1'b0, 10'h010, 4'h0, '0);
        @(negedge clk);
        check("abandon a_ack", 32'(ia.ack), 32'h1);
        check("abandon b_ack", 32'(ib.ack), 32'h0);
        @(posedge clk);
        #1;
        set_ch(0, 1'b0, 1'b0, '0, '0, '0);
        set_ch(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("abandon b_rvalid", 32'(ib.rvalid), 32'h0);
        @(posedge clk);
        #1;

        // Reset right after a granted read cancels its rvalid pulse
        set_ch(0, 1'b1, 1'b0, 10'h010, 4'h0, '0);
        @(negedge clk);
        check("abort a_ack", 32'(ia.ack), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_ch(0, 1'b1, 1'b1, 10'h010, 4'hF, 32'hFFFFFFFF);
        @(negedge clk);
        check("abort a_rvalid", 32'(ia.rvalid), 32'h0);
        check("abort a_rdata", ia.rdata, 32'h0);
        check("abort a_ack_in_rst", 32'(ia.ack), 32'h0);
        @(posedge clk);
        #1;
        set_ch(0, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        // The write presented during reset must not have landed
        access(0, 1'b0, 10'h010, 4'h0, '0, 32'hDEADBE55, 1'b0);

`ifdef SRAM_ARB2P_PARITY_EN
        access(0, 1'b1, 10'h040, 4'hF, 32'h13579BDF, 32'h0, 1'b0);
        access(0, 1'b0, 10'h040, 4'h0, '0, 32'h13579BDF, 1'b0);
        u0.mem[64] = u0.mem[64] ^ 32'h00000100;
        access(0, 1'b0, 10'h040, 4'h0, '0, 32'h13579ADF, 1'b1);
        access(3, 1'b0, 10'h3F0, 4'h0, '0, 32'h00000000, 1'b0);
`endif

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pending_reads ch%0d", k), 32'(sbq[k].size()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
